// File: rtl/tc_pl_cap_pkg.sv
// Shared definitions for the capture-stream source: default widths and FSM states.
package tc_pl_cap_pkg;

  localparam int CAP0_6  = 14;  // cap_points / point counter width
  localparam int ADC_W   = 28;  // one ADC channel sample
  localparam int ADC0_1  = 56;  // merged {adc1, adc0} word, 2*ADC_W
  localparam int FIFO_AW = 4;   // FIFO depth = 2**FIFO_AW

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/tc_pl_cap_sfifo.sv
// Single-clock show-ahead FIFO. Head word is visible on dout whenever !empty.
// A push on a full FIFO is accepted if a pop happens in the same cycle.
// dout is forced to zero while empty so the stream data bus idles at 0.
module tc_pl_cap_sfifo #(
  parameter int DW = 56,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // Pop frees the slot first, so a full FIFO still takes a simultaneous push.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tc_pl_cap_data_merge_src.sv
// Source side of the merge capture stream: packs {adc1, adc0} into one word,
// buffers it in a show-ahead FIFO and hands it out with valid/ready, stopping
// after cap_points words are written or when the consumer reports completion.
module tc_pl_cap_data_merge_src
  import tc_pl_cap_pkg::*;
#(
  parameter int CAP0_6  = tc_pl_cap_pkg::CAP0_6,
  parameter int ADC_W   = tc_pl_cap_pkg::ADC_W,
  parameter int ADC0_1  = tc_pl_cap_pkg::ADC0_1,
  parameter int FIFO_AW = tc_pl_cap_pkg::FIFO_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [CAP0_6-1:0] cap_points,
  input  logic [ADC_W-1:0]  adc0_data,
  input  logic [ADC_W-1:0]  adc1_data,
  input  logic              adc_valid,
  output logic [ADC0_1-1:0] Gc_merge_data,
  output logic              Gc_mereg_datv,
  input  logic              Gc_mereg_datr,
  input  logic              Gc_cap_cmpt,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CAP0_6-1:0] sent_cnt
);

  cap_state_e        state;
  logic              cap_en_d;
  logic [CAP0_6-1:0] pts_q;
  logic [CAP0_6-1:0] wr_cnt;

  logic fifo_full, fifo_empty;
  logic xfer, flush, want, fifo_push, accept, drop;

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  assign Gc_mereg_datv = ~fifo_empty;
  assign xfer          = Gc_mereg_datv & Gc_mereg_datr;

  // Dropping cap_en aborts from any state; completion aborts an active capture.
  assign flush     = ~cap_en | (Gc_cap_cmpt & busy);
  assign want      = (state == ST_RUN) & adc_valid & (wr_cnt != pts_q);
  assign fifo_push = want & ~flush;
  assign accept    = fifo_push & (~fifo_full | xfer);
  assign drop      = fifo_push & fifo_full & ~xfer;

  tc_pl_cap_sfifo #(
    .DW (ADC0_1),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (xfer),
    .flush (flush),
    .din   ({adc1_data, adc0_data}),
    .dout  (Gc_merge_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Capture FSM with write/sent counters and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cap_en_d <= 1'b0;
      pts_q    <= '0;
      wr_cnt   <= '0;
      sent_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      cap_en_d <= cap_en;
      if (xfer && (sent_cnt != '1)) sent_cnt <= sent_cnt + 1'b1;
      if (accept) wr_cnt <= wr_cnt + 1'b1;
      if (drop)   overflow <= 1'b1;

      if (!cap_en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!cap_en_d) begin
              pts_q    <= cap_points;
              wr_cnt   <= '0;
              sent_cnt <= '0;
              overflow <= 1'b0;
              state    <= (cap_points == '0) ? ST_DONE : ST_RUN;
            end
          end
          ST_RUN: begin
            if (Gc_cap_cmpt)
              state <= ST_DONE;
            else if (accept && (wr_cnt + 1'b1 == pts_q))
              state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (Gc_cap_cmpt || fifo_empty) state <= ST_DONE;
          end
          default: state <= ST_DONE;  // DONE holds until cap_en falls
        endcase
      end
    end
  end

endmodule
